// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller: guard/show slot timing,
// frame-synchronous display updates through a one-deep pending buffer, and leading-zero blanking.
module seg_scan_ctrl #(
  parameter int DIV_MAX = 50000,
  parameter int GUARD   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        lzb,
  output logic [3:0]  an_n,
  output logic [3:0]  nibble,
  output logic        dp_n,
  output logic        frame_done
);

  localparam int CW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_MAX - 1);
  localparam logic [CW-1:0] GRD_LAST = CW'(GUARD - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_GUARD, ST_SHOW} state_t;

  typedef struct packed {
    logic [15:0] dat;
    logic [3:0]  dp;
  } seg_frame_t;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  seg_frame_t pend_q, pend_d, disp_q, disp_d;
  logic       ready_q, ready_d;
  logic [3:0] an_q, an_d, nib_q, nib_d;
  logic       dpn_q, dpn_d, fd_q, fd_d;
  logic [3:0] blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      disp_q  <= '0;
      ready_q <= 1'b1;
      an_q    <= 4'hF;
      nib_q   <= 4'h0;
      dpn_q   <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      ready_q <= ready_d;
      an_q    <= an_d;
      nib_q   <= nib_d;
      dpn_q   <= dpn_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fd_d    = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_GUARD;
          idx_d   = '0;
          cnt_d   = '0;
        end
        ST_GUARD: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == GRD_LAST) state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_GUARD;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            fd_d    = (idx_q == 2'd3);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Transfer uses the frame_done register, so a load taken in that same cycle waits a frame.
  always_comb begin
    pend_d  = pend_q;
    disp_d  = disp_q;
    ready_d = ready_q;
    if (!ready_q && (state_q == ST_IDLE || fd_q)) begin
      disp_d  = pend_q;
      ready_d = 1'b1;
    end
    if (ready_q && load_valid) begin
      pend_d.dat = data_in;
      pend_d.dp  = dp_in;
      ready_d    = 1'b0;
    end
  end

  always_comb begin
    blank = '0;
    for (int i = 1; i < 4; i++)
      blank[i] = lzb && ((disp_d.dat >> (4 * i)) == 16'h0) && ((disp_d.dp >> i) == 4'h0);
  end

  always_comb begin
    an_d  = 4'hF;
    nib_d = 4'h0;
    dpn_d = 1'b1;
    if (state_d == ST_SHOW) begin
      nib_d = disp_d.dat[{idx_d, 2'b00} +: 4];
      dpn_d = ~disp_d.dp[idx_d];
      if (!blank[idx_d]) an_d = ~(4'b0001 << idx_d);
    end
  end

  assign load_ready = ready_q;
  assign an_n       = an_q;
  assign nibble     = nib_q;
  assign dp_n       = dpn_q;
  assign frame_done = fd_q;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV_MAX, default 50000, clocks per digit slot (1 kHz slot at 50 MHz).
REQ-002 SHALL have parameter GUARD, default 16, anode-off clocks at the start of each slot; legal range 1 <= GUARD < DIV_MAX.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1 bit: system clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: 1 = scan the display, 0 = all digits dark.
REQ-007 SHALL have port load_valid, input, 1 bit: new display value offered.
REQ-008 SHALL have port load_ready, output, 1 bit: 1 = load accepted this cycle if load_valid=1.
REQ-009 SHALL have port data_in, input, 16 bits: four hex nibbles; [3:0] is digit 0 (rightmost).
REQ-010 SHALL have port dp_in, input, 4 bits: decimal point per digit, 1 = lit.
REQ-011 SHALL have port lzb, input, 1 bit: leading-zero blanking enable, sampled every cycle.
REQ-012 SHALL have port an_n, output, 4 bits: active-low digit anode enables.
REQ-013 SHALL have port nibble, output, 4 bits: hex value driven to the shared segment decoder.
REQ-014 SHALL have port dp_n, output, 1 bit: active-low decimal point.
REQ-015 SHALL have port frame_done, output, 1 bit: one-cycle pulse when digit 3's slot ends.

Function
REQ-016 SHALL implement FSM states IDLE, GUARD and SHOW, plus a digit index idx (0..3), a slot counter (0..DIV_MAX-1), a pending register and a display register.
REQ-017 SHALL move from IDLE to GUARD with idx=0 and counter=0 on the first edge where enable=1.
REQ-018 SHALL, in GUARD, hold an_n=4'b1111 for exactly GUARD cycles, then enter SHOW.
REQ-019 SHALL, in SHOW, drive an_n[idx]=0 and all other bits 1, nibble=disp[4*idx+:4] and dp_n=~dp[idx], for exactly DIV_MAX-GUARD cycles.
REQ-020 SHALL, at the end of SHOW, increment idx (wrapping 3 to 0), reset the counter and enter GUARD.
REQ-021 SHALL, on the wrap from 3 to 0, pulse frame_done for exactly one cycle.
REQ-022 SHALL enter IDLE on the edge after enable falls, from any state: an_n=4'b1111, dp_n=1, idx=0, counter=0; the current slot is abandoned.
REQ-023 SHALL complete a load handshake when load_valid=1 and load_ready=1 on the same edge: data_in and dp_in go into the pending register and load_ready=0 from the next cycle.
REQ-024 SHALL copy pending into the display register, and set load_ready=1 on the following cycle, only at a frame boundary (the frame_done cycle) or, while in IDLE, on the cycle after capture; display contents never change mid-frame.
REQ-025 SHALL, when a load is accepted in the same cycle as frame_done, keep the old display and transfer the new value at the next frame boundary.
REQ-026 SHALL ignore load_valid while load_ready=0, leaving pending unchanged.
REQ-027 SHALL, when lzb=1, keep an_n[idx]=1 during SHOW for any digit idx>0 whose nibble and every higher display nibble are 0 with no dp lit at or above idx; digit 0 is always shown; timing is unchanged.
REQ-028 SHALL register all outputs; an_n never has more than one bit at 0 in any cycle.

Reset
REQ-029 SHALL, while rst_n=0, immediately set an_n=4'b1111, nibble=4'h0, dp_n=1, frame_done=0, load_ready=1, state=IDLE, idx=0, counter=0, and clear pending and display to 0.
REQ-030 SHALL, after rst_n rises mid-scan, resume from IDLE with no glitch on an_n.

Verification (DIV_MAX=8, GUARD=2)
REQ-031 SHALL test basic scan: reset, load 16'h1234 with dp_in=0, enable=1 -> repeating sequence of 2 cycles an_n=1111, then 6 cycles an_n=1110 with nibble=4, then 1101/3, 1011/2, 0111/1; frame_done pulses once every 32 cycles.
REQ-032 SHALL test a mid-frame load: load 16'hABCD during digit 1 -> load_ready=0 until frame_done; the remaining digits of that frame still show 1234, and the next frame shows D,C,B,A.
REQ-033 SHALL test leading-zero blanking: display 16'h0050, lzb=1 -> digits 2 and 3 keep an_n=1111 through their slots; digit 1 shows 5; digit 0 shows 0.
REQ-034 SHALL test enable drop: enable=0 during SHOW of digit 2 -> an_n=1111 on the next cycle; re-enable restarts at GUARD with digit 0.
REQ-035 SHALL test async reset: assert rst_n=0 mid-SHOW -> an_n=1111 and load_ready=1 without waiting for a clock edge, and display reads 0 after release.
REQ-036 SHALL test back-to-back loads: load_valid held at 1 with two values -> only the first is accepted; the second is accepted on the cycle load_ready returns to 1.
